lp_sched: RTL and testbench

LP_SCHED -- requirements
Module: lp_sched

---
 rtl/lp_pkg.sv | 20 ++
 rtl/lp_rr_arb.sv | 30 +++
 rtl/lp_sched.sv | 153 +++++++++++++++
 tb/tb_lp_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared types and constants for the LP solver scheduler
package lp_pkg;

    localparam int LP_FRAME_BEATS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lp_state_e;

    typedef struct packed {
        logic signed [5:0]  a1;
        logic signed [5:0]  a2;
        logic signed [11:0] b;
    } lp_beat_t;

endpackage

// File: rtl/lp_rr_arb.sv
// rtl/lp_rr_arb.sv - round-robin pick of the first request at or after a pointer
module lp_rr_arb #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_valid && i_req[wrap_idx(i_ptr, k)]) begin
                o_gnt[wrap_idx(i_ptr, k)] = 1'b1;
                o_valid                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lp_sched.sv
// rtl/lp_sched.sv - shares one LP solver core among NREQ requesters; LP_SCHED_TIMEOUT_EN adds a WAIT watchdog
module lp_sched
    import lp_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         rq_valid,
    input  logic [NREQ-1:0][5:0]    rq_a1,
    input  logic [NREQ-1:0][5:0]    rq_a2,
    input  logic [NREQ-1:0][11:0]   rq_b,
    output logic [NREQ-1:0]         rq_ready,
    output logic                    lp_in_valid,
    output logic signed [5:0]       lp_in_a1,
    output logic signed [5:0]       lp_in_a2,
    output logic signed [11:0]      lp_in_b,
    input  logic                    lp_out_valid,
    input  logic signed [11:0]      lp_out_max_value,
    output logic [NREQ-1:0]         rsp_valid,
    output logic signed [11:0]      rsp_value,
    output logic                    rsp_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] LAST_BEAT = 3'(LP_FRAME_BEATS - 1);

    lp_state_e          r_state;
    lp_state_e          w_state_nxt;
    logic [PW-1:0]      r_grant;
    logic [PW-1:0]      r_rr_ptr;
    logic [2:0]         r_cnt;
    lp_beat_t           r_buf [LP_FRAME_BEATS];
    logic signed [11:0] r_result;
    logic               r_err;

    logic [NREQ-1:0]    w_arb_gnt;
    logic               w_arb_valid;
    logic [PW-1:0]      w_arb_idx;
    logic [NREQ-1:0]    w_owner_1h;
    logic               w_accept;
    logic               w_timeout;

    lp_rr_arb #(.N(NREQ), .PW(PW)) u_arb (
        .i_req   (rq_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_arb_idx  = '0;
        w_owner_1h = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_gnt[k]) w_arb_idx = PW'(k);
            w_owner_1h[k] = (r_grant == PW'(k));
        end
    end

    assign w_accept = (r_state == ST_COLLECT) && |(rq_valid & w_owner_1h);

`ifdef LP_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_wait_cnt <= '0;
        else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
        else                        r_wait_cnt <= '0;
    end

    // Counter starts at 0 in the first WAIT cycle, so TIMEOUT_CYC-1 marks the last one.
    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_arb_valid) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_accept && r_cnt == LAST_BEAT) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (r_cnt == LAST_BEAT) w_state_nxt = ST_WAIT;
            ST_WAIT:    if (lp_out_valid || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            for (int k = 0; k < LP_FRAME_BEATS; k++) r_buf[k] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant  <= w_arb_idx;
                        r_rr_ptr <= (w_arb_idx == PW'(NREQ - 1)) ? '0 : w_arb_idx + PW'(1);
                        r_cnt    <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_buf[r_cnt] <= {rq_a1[r_grant], rq_a2[r_grant], rq_b[r_grant]};
                        r_cnt        <= (r_cnt == LAST_BEAT) ? 3'd0 : r_cnt + 3'd1;
                    end
                end
                ST_ISSUE: r_cnt <= (r_cnt == LAST_BEAT) ? 3'd0 : r_cnt + 3'd1;
                ST_WAIT: begin
                    // A real result wins over a watchdog expiry in the same cycle.
                    if (lp_out_valid) begin
                        r_result <= lp_out_max_value;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rq_ready    = (r_state == ST_COLLECT) ? w_owner_1h : '0;
        lp_in_valid = (r_state == ST_ISSUE);
        lp_in_a1    = '0;
        lp_in_a2    = '0;
        lp_in_b     = '0;
        if (r_state == ST_ISSUE) begin
            lp_in_a1 = r_buf[r_cnt].a1;
            lp_in_a2 = r_buf[r_cnt].a2;
            lp_in_b  = r_buf[r_cnt].b;
        end
        rsp_valid = (r_state == ST_RESP) ? w_owner_1h : '0;
        rsp_value = (r_state == ST_RESP) ? r_result : '0;
        rsp_err   = (r_state == ST_RESP) && r_err;
    end

endmodule

// File: tb/tb_lp_sched.sv
// tb/tb_lp_sched.sv - randomized self-checking bench for lp_sched with a frame-level reference model
module tb_lp_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       rq_valid = '0;
    logic [NREQ-1:0][5:0]  rq_a1 = '0;
    logic [NREQ-1:0][5:0]  rq_a2 = '0;
    logic [NREQ-1:0][11:0] rq_b = '0;
    logic [NREQ-1:0]       rq_ready;
    logic                  lp_in_valid;
    logic signed [5:0]     lp_in_a1;
    logic signed [5:0]     lp_in_a2;
    logic signed [11:0]    lp_in_b;
    logic                  lp_out_valid = 1'b0;
    logic signed [11:0]    lp_out_max_value = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic signed [11:0]    rsp_value;
    logic                  rsp_err;

    lp_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rq_valid         (rq_valid),
        .rq_a1            (rq_a1),
        .rq_a2            (rq_a2),
        .rq_b             (rq_b),
        .rq_ready         (rq_ready),
        .lp_in_valid      (lp_in_valid),
        .lp_in_a1         (lp_in_a1),
        .lp_in_a2         (lp_in_a2),
        .lp_in_b          (lp_in_b),
        .lp_out_valid     (lp_out_valid),
        .lp_out_max_value (lp_out_max_value),
        .rsp_valid        (rsp_valid),
        .rsp_value        (rsp_value),
        .rsp_err          (rsp_err)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;

    // Requester-side model: pending frame, beat pointer, stall plan.
    logic [23:0] fr [NREQ][7];
    int          bptr [NREQ];
    bit          has_fr [NREQ];
    int          st_after [NREQ];
    int          st_len [NREQ];
    int          st_cnt [NREQ];
    int          exp_ptr;

    logic [23:0] iss_q [$];
    int          iss_first, iss_last, last_acc, cyc;
    int          owner_seen, acc_other;
    int          rsp_cnt, rsp_cyc;
    logic [3:0]  rsp_v;
    logic [11:0] rsp_val;
    logic        rsp_e;
    bit          sol_en, sol_fired, fire_next;
    int          sol_cd;
    logic [11:0] sol_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int a1, input int a2, input int b);
        return {a1[5:0], a2[5:0], b[11:0]};
    endfunction

    function automatic int predict();
        int o;
        o = -1;
        for (int k = 0; k < NREQ; k++)
            if (o < 0 && has_fr[(exp_ptr + k) % NREQ]) o = (exp_ptr + k) % NREQ;
        return o;
    endfunction

    function automatic bit any_pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) p = p | has_fr[i];
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (st_cnt[i] > 0) begin
                rq_valid[i] = 1'b0;
                st_cnt[i]--;
            end else begin
                rq_valid[i] = has_fr[i];
            end
            if (has_fr[i]) {rq_a1[i], rq_a2[i], rq_b[i]} = fr[i][bptr[i]];
            else           {rq_a1[i], rq_a2[i], rq_b[i]} = '0;
        end
        lp_out_valid     = fire_next;
        lp_out_max_value = fire_next ? sol_val : 12'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("ready_onehot0", 32'($onehot0(rq_ready)), 32'd1);
        if (!lp_in_valid) begin
            chk("lp_in_zero_when_idle", 32'({lp_in_a1, lp_in_a2, lp_in_b}), 32'd0);
        end else begin
            iss_q.push_back({lp_in_a1, lp_in_a2, lp_in_b});
            if (iss_q.size() == 1) iss_first = cyc;
            iss_last = cyc;
        end
        if (rsp_valid != '0) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_v   = rsp_valid;
            rsp_val = rsp_value;
            rsp_e   = rsp_err;
        end
        for (int i = 0; i < NREQ; i++)
            if (has_fr[i] && bptr[i] > 0 && !rq_valid[i])
                chk("stall_grant_held", 32'(rq_ready), 32'(1 << i));
        for (int i = 0; i < NREQ; i++) begin
            if (rq_valid[i] && rq_ready[i]) begin
                if (owner_seen < 0) owner_seen = i;
                else if (owner_seen != i) acc_other++;
                bptr[i]++;
                last_acc = cyc;
                if (bptr[i] == 7) has_fr[i] = 1'b0;
                else if (bptr[i] == st_after[i]) st_cnt[i] = st_len[i];
            end
        end
        fire_next = 1'b0;
        if (sol_en && !sol_fired && iss_q.size() == 7 && !lp_in_valid) begin
            if (sol_cd == 0) begin
                fire_next = 1'b1;
                sol_fired = 1'b1;
            end else begin
                sol_cd--;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic fill_rand(input int i);
        for (int k = 0; k < 7; k++)
            fr[i][k] = {6'($urandom), 6'($urandom), (k == 0) ? 12'd0 : 12'($urandom)};
    endtask

    task automatic arm(input int i, input int sa, input int sl);
        has_fr[i]   = 1'b1;
        bptr[i]     = 0;
        st_after[i] = sa;
        st_len[i]   = sl;
        st_cnt[i]   = 0;
        rq_valid[i] = 1'b1;
        {rq_a1[i], rq_a2[i], rq_b[i]} = fr[i][0];
    endtask

    task automatic clear_job();
        iss_q.delete();
        rsp_cnt    = 0;
        owner_seen = -1;
        acc_other  = 0;
        sol_fired  = 1'b0;
        last_acc   = -100;
        iss_first  = -1;
        iss_last   = -1;
    endtask

    task automatic run_job(input int exp_owner, input logic [11:0] exp_val, input logic exp_err,
                           input bit sol, input int delay);
        clear_job();
        sol_en  = sol;
        sol_cd  = delay;
        sol_val = exp_val;
        for (int t = 0; t < 300 && rsp_cnt == 0; t++) tick();
        chk("rsp_seen", 32'(rsp_cnt), 32'd1);
        chk("grant_owner", 32'(owner_seen), 32'(exp_owner));
        chk("beats_from_owner_only", 32'(acc_other), 32'd0);
        chk("rsp_valid_route", 32'(rsp_v), 32'(1 << exp_owner));
        chk("rsp_value", 32'(rsp_val), 32'(exp_val));
        chk("rsp_err", 32'(rsp_e), 32'(exp_err));
        chk("issue_beat_count", 32'(iss_q.size()), 32'd7);
        for (int k = 0; k < iss_q.size() && k < 7; k++)
            chk("issue_beat_data", 32'(iss_q[k]), 32'(fr[exp_owner][k]));
        chk("issue_contiguous", 32'(iss_last - iss_first), 32'd6);
        chk("issue_latency", 32'(iss_first), 32'(last_acc + 1));
        repeat (2) tick();
        chk("rsp_single_pulse", 32'(rsp_cnt), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            has_fr[i] = 1'b0;
            bptr[i]   = 0;
            st_cnt[i] = 0;
        end
        fire_next = 1'b0;
        sol_en    = 1'b0;
        exp_ptr   = 0;
        drive();
        repeat (2) tick();
        chk("rst_rq_ready", 32'(rq_ready), 32'd0);
        chk("rst_lp_in_valid", 32'(lp_in_valid), 32'd0);
        chk("rst_lp_in_data", 32'({lp_in_a1, lp_in_a2, lp_in_b}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_value", 32'(rsp_value), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int o;
        int mask;
        logic [11:0] v;

        cyc = 0;
        clear_job();
        for (int i = 0; i < NREQ; i++) begin
            has_fr[i] = 1'b0; bptr[i] = 0; st_after[i] = -1; st_len[i] = 0; st_cnt[i] = 0;
        end
        exp_ptr = 0;
        sol_en  = 1'b0;
        fire_next = 1'b0;

        do_reset();

        // Spurious solver result while idle must be ignored.
        clear_job();
        lp_out_valid     = 1'b1;
        lp_out_max_value = 12'h055;
        repeat (5) tick();
        chk("spurious_no_rsp", 32'(rsp_cnt), 32'd0);
        chk("spurious_no_ready", 32'(rq_ready), 32'd0);

        // Directed single job on requester 2.
        fr[2][0] = mk(3, 2, 0);   fr[2][1] = mk(1, 0, 5);  fr[2][2] = mk(-1, 0, 0);
        fr[2][3] = mk(0, 1, 4);   fr[2][4] = mk(0, -1, 0); fr[2][5] = mk(1, 1, 6);
        fr[2][6] = mk(2, 1, 10);
        arm(2, -1, 0);
        o = predict();
        exp_ptr = (o + 1) % NREQ;
        run_job(2, 12'd14, 1'b0, 1'b1, 2);

        // Contention: all four requesting right after reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            fill_rand(i);
            arm(i, -1, 0);
        end
        for (int j = 0; j < NREQ; j++) begin
            o = predict();
            exp_ptr = (o + 1) % NREQ;
            v = 12'($urandom);
            run_job(j, v, 1'b0, 1'b1, $urandom_range(0, 4));
        end

        // Requester 1 stalls for 3 cycles after beat 4.
        fill_rand(1);
        arm(1, 4, 3);
        o = predict();
        exp_ptr = (o + 1) % NREQ;
        run_job(1, 12'($urandom), 1'b0, 1'b1, 1);

        // Randomized mixes of requesters, stalls and solver delays.
        repeat (6) begin
            mask = $urandom_range(1, 15);
            for (int i = 0; i < NREQ; i++)
                if (mask[i]) begin
                    fill_rand(i);
                    arm(i, $urandom_range(1, 6), $urandom_range(0, 3));
                end
            for (int g = 0; g < 8 && any_pending(); g++) begin
                o = predict();
                exp_ptr = (o + 1) % NREQ;
                v = 12'($urandom);
                run_job(o, v, 1'b0, 1'b1, $urandom_range(0, 4));
            end
        end

        // Reset while waiting on the solver: job dropped, pointer back to 0.
        fill_rand(1);
        arm(1, -1, 0);
        clear_job();
        sol_en = 1'b0;
        for (int t = 0; t < 100 && !(iss_q.size() == 7 && !lp_in_valid); t++) tick();
        chk("wait_job_issued", 32'(iss_q.size()), 32'd7);
        repeat (3) tick();
        rsp_cnt = 0;
        do_reset();
        repeat (5) tick();
        chk("reset_in_wait_no_rsp", 32'(rsp_cnt), 32'd0);
        fill_rand(2);
        arm(2, -1, 0);
        fill_rand(0);
        arm(0, -1, 0);
        o = predict();
        exp_ptr = (o + 1) % NREQ;
        run_job(0, 12'($urandom), 1'b0, 1'b1, 0);
        o = predict();
        exp_ptr = (o + 1) % NREQ;
        run_job(2, 12'($urandom), 1'b0, 1'b1, 3);

`ifdef LP_SCHED_TIMEOUT_EN
        fill_rand(3);
        arm(3, -1, 0);
        o = predict();
        exp_ptr = (o + 1) % NREQ;
        run_job(3, 12'd0, 1'b1, 1'b0, 0);
        chk("timeout_cycle", 32'(rsp_cyc), 32'(iss_last + TMO + 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
